// File: rtl/uart_rx_loader.sv
// uart_rx_loader: receives 8N1 UART bytes from the host and loads them
// sequentially into the kernel BRAM (first KERNEL_LEN bytes) and then the
// image BRAM (next IMAGE_LEN bytes), raising sticky completion flags.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rx             UART serial input (idle high, asynchronous to clk)
//   kernel_we      one-cycle write strobe to the kernel BRAM
//   image_we       one-cycle write strobe to the image BRAM
//   wr_addr        write address shared by both BRAMs
//   wr_data        received byte
//   kernel_loaded  sticky: all kernel bytes written
//   image_loaded   sticky: all image bytes written
//   frame_err      sticky: a stop bit was sampled low
module uart_rx_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned KERNEL_LEN   = 9,
  parameter int unsigned IMAGE_LEN    = 16384,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              kernel_we,
  output logic              image_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              kernel_loaded,
  output logic              image_loaded,
  output logic              frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  typedef enum logic [1:0] {
    PH_KERNEL,
    PH_IMAGE,
    PH_DONE
  } phase_t;

  // 2-FF synchroniser, idles high so reset never looks like a start bit
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t        rx_state_q, rx_state_n;
  logic [CNT_W-1:0] baud_q, baud_n;
  logic [2:0]       bit_q, bit_n;
  logic [7:0]       shift_q, shift_n;
  logic             frame_err_n;
  logic             byte_valid_c;
  logic             tick_c;

  assign tick_c = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_n;
      baud_q     <= baud_n;
      bit_q      <= bit_n;
      shift_q    <= shift_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state_q;
    baud_n       = baud_q;
    bit_n        = bit_q;
    shift_n      = shift_q;
    frame_err_n  = frame_err;
    byte_valid_c = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!rx_s) rx_state_n = RX_START;
      end

      // Mid-start-bit check rejects short glitches
      RX_START: begin
        if (baud_q == CNT_W'(HALF - 1)) begin
          baud_n     = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (tick_c) begin
          baud_n  = '0;
          shift_n = {rx_s, shift_q[7:1]};
          bit_n   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_state_n = RX_STOP;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      // Leaving at mid-stop lets a back-to-back start bit be caught
      RX_STOP: begin
        if (tick_c) begin
          baud_n = '0;
          if (rx_s) begin
            byte_valid_c = 1'b1;
            rx_state_n   = RX_IDLE;
          end else begin
            frame_err_n = 1'b1;
            rx_state_n  = RX_RECOVER;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      // Wait out a break so it never produces bytes
      RX_RECOVER: begin
        baud_n = '0;
        if (rx_s) rx_state_n = RX_IDLE;
      end

      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  phase_t            phase_q, phase_n;
  logic [ADDR_W-1:0] count_q, count_n;
  logic              kernel_we_n;
  logic              image_we_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              kernel_loaded_n;
  logic              image_loaded_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PH_KERNEL;
      count_q       <= '0;
      kernel_we     <= 1'b0;
      image_we      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      kernel_loaded <= 1'b0;
      image_loaded  <= 1'b0;
    end else begin
      phase_q       <= phase_n;
      count_q       <= count_n;
      kernel_we     <= kernel_we_n;
      image_we      <= image_we_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      kernel_loaded <= kernel_loaded_n;
      image_loaded  <= image_loaded_n;
    end
  end

  always_comb begin
    phase_n         = phase_q;
    count_n         = count_q;
    kernel_we_n     = 1'b0;
    image_we_n      = 1'b0;
    wr_addr_n       = wr_addr;
    wr_data_n       = wr_data;
    kernel_loaded_n = kernel_loaded;
    image_loaded_n  = image_loaded;

    if (byte_valid_c) begin
      case (phase_q)
        PH_KERNEL: begin
          kernel_we_n = 1'b1;
          wr_addr_n   = count_q;
          wr_data_n   = shift_q;
          if (count_q == ADDR_W'(KERNEL_LEN - 1)) begin
            kernel_loaded_n = 1'b1;
            count_n         = '0;
            phase_n         = PH_IMAGE;
          end else begin
            count_n = count_q + 1'b1;
          end
        end

        PH_IMAGE: begin
          image_we_n = 1'b1;
          wr_addr_n  = count_q;
          wr_data_n  = shift_q;
          if (count_q == ADDR_W'(IMAGE_LEN - 1)) begin
            image_loaded_n = 1'b1;
            phase_n        = PH_DONE;
          end else begin
            count_n = count_q + 1'b1;
          end
        end

        // Load complete: bytes are received and discarded
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader with a small configuration
// (16 clocks/bit, 3 kernel bytes, 4 image bytes, 4-bit address).
module tb_uart_rx_loader;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       kernel_we;
  logic       image_we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       kernel_loaded;
  logic       image_loaded;
  logic       frame_err;

  uart_rx_loader #(
    .CLKS_PER_BIT(CPB),
    .KERNEL_LEN  (3),
    .IMAGE_LEN   (4),
    .ADDR_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .kernel_we    (kernel_we),
    .image_we     (image_we),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .kernel_loaded(kernel_loaded),
    .image_loaded (image_loaded),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  // Captured write strobe with the flag values seen in the same cycle
  typedef struct packed {
    logic       img;
    logic [3:0] addr;
    logic [7:0] data;
    logic       kl;
    logic       il;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (kernel_we && image_we) overlap_cnt++;
    if (kernel_we || image_we)
      wq.push_back('{img: image_we, addr: wr_addr, data: wr_data,
                     kl: kernel_loaded, il: image_loaded});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Expect exactly one strobe of the given kind/address/data in the queue
  task automatic expect_write(input string name, input logic img, input logic [3:0] addr,
                              input logic [7:0] data, input logic kl, input logic il);
    wr_t w;
    chk({name, " strobe count"}, 32'(wq.size()), 32'd1);
    if (wq.size() != 0) begin
      w = wq.pop_front();
      chk({name, " bram select"}, 32'(w.img), 32'(img));
      chk({name, " addr"}, 32'(w.addr), 32'(addr));
      chk({name, " data"}, 32'(w.data), 32'(data));
      chk({name, " kernel_loaded at strobe"}, 32'(w.kl), 32'(kl));
      chk({name, " image_loaded at strobe"}, 32'(w.il), 32'(il));
    end
    wq.delete();
  endtask

  typedef struct {
    logic       rst_first;
    logic [7:0] data;
    logic       exp_we;
    logic       exp_img;
    logic [3:0] exp_wa;
    logic [7:0] exp_wd;
    logic       exp_kl;
    logic       exp_il;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //          rst   data   we    img   addr  wdata  kl    il
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b0, 4'd1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 1'b1, 1'b0, 4'd2, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h10, 1'b1, 1'b1, 4'd0, 8'h10, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h20, 1'b1, 1'b1, 4'd1, 8'h20, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h30, 1'b1, 1'b1, 4'd2, 8'h30, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h40, 1'b1, 1'b1, 4'd3, 8'h40, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 8'h55, 1'b0, 1'b0, 4'd3, 8'h40, 1'b1, 1'b1};

    reset = 1'b1;
    rx    = 1'b1;
    #1;
    chk("reset kernel_we", 32'(kernel_we), 32'd0);
    chk("reset image_we", 32'(image_we), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_data", 32'(wr_data), 32'd0);
    chk("reset kernel_loaded", 32'(kernel_loaded), 32'd0);
    chk("reset image_loaded", 32'(image_loaded), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    do_reset();

    // Table-driven load sequence (back-to-back frames between resets)
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst_first) do_reset();
      send_byte(vecs[v].data, 1'b1);
      if (vecs[v].exp_we)
        expect_write($sformatf("vec%0d", v), vecs[v].exp_img, vecs[v].exp_wa,
                     vecs[v].exp_wd, vecs[v].exp_kl, vecs[v].exp_il);
      else begin
        chk($sformatf("vec%0d no strobe", v), 32'(wq.size()), 32'd0);
        wq.delete();
      end
      chk($sformatf("vec%0d wr_addr hold", v), 32'(wr_addr), 32'(vecs[v].exp_wa));
      chk($sformatf("vec%0d wr_data hold", v), 32'(wr_data), 32'(vecs[v].exp_wd));
      chk($sformatf("vec%0d kernel_loaded", v), 32'(kernel_loaded), 32'(vecs[v].exp_kl));
      chk($sformatf("vec%0d image_loaded", v), 32'(image_loaded), 32'(vecs[v].exp_il));
      chk($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'd0);
    end

    // Short low glitch while idle is rejected
    do_reset();
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch no strobe", 32'(wq.size()), 32'd0);
    chk("glitch frame_err", 32'(frame_err), 32'd0);
    wq.delete();
    send_byte(8'h3C, 1'b1);
    expect_write("after glitch", 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0);

    // Framing error followed by a break, then a good byte
    do_reset();
    send_byte(8'h77, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr flag", 32'(frame_err), 32'd1);
    chk("ferr no strobe", 32'(wq.size()), 32'd0);
    wq.delete();
    send_byte(8'h12, 1'b1);
    expect_write("after ferr", 1'b0, 4'd0, 8'h12, 1'b0, 1'b0);
    chk("ferr sticky", 32'(frame_err), 32'd1);

    // Reset in the middle of data bit 4 of the second kernel byte
    do_reset();
    send_byte(8'h01, 1'b1);
    expect_write("pre-abort byte", 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort kernel_we", 32'(kernel_we), 32'd0);
    chk("abort wr_addr", 32'(wr_addr), 32'd0);
    chk("abort wr_data", 32'(wr_data), 32'd0);
    chk("abort kernel_loaded", 32'(kernel_loaded), 32'd0);
    chk("abort frame_err", 32'(frame_err), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    chk("abort no strobe", 32'(wq.size()), 32'd0);
    send_byte(8'h9A, 1'b1);
    expect_write("after abort", 1'b0, 4'd0, 8'h9A, 1'b0, 1'b0);

    chk("strobe overlap count", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Upstream loading stage for the convolution accelerator.
- Receives serial bytes from the host PC over UART (8N1).
- Writes the first KERNEL_LEN bytes sequentially into the kernel BRAM, then the next IMAGE_LEN bytes into the image BRAM.
- Raises sticky completion flags that gate the start of convolution, mirroring the outbound UART path.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).
- KERNEL_LEN, 9, number of kernel bytes (3x3 kernel, signed 8-bit).
- IMAGE_LEN, 16384, number of image bytes (128x128 pixels, unsigned 8-bit).
- ADDR_W, 16, write address width; must satisfy 2^ADDR_W >= max(KERNEL_LEN, IMAGE_LEN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  UART serial input, idle high, asynchronous to clk
- kernel_we  output  1  one-cycle write strobe to kernel BRAM
- image_we  output  1  one-cycle write strobe to image BRAM
- wr_addr  output  ADDR_W  write address, shared by both BRAMs
- wr_data  output  8  received byte
- kernel_loaded  output  1  sticky: all KERNEL_LEN bytes written
- image_loaded  output  1  sticky: all IMAGE_LEN bytes written
- frame_err  output  1  sticky: a stop bit was sampled low

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0, the RX FSM to IDLE, the loader to phase KERNEL, and the byte counter to 0. Asserting reset mid-byte or mid-load aborts that byte and discards all progress.
- rx is passed through a 2-FF synchroniser, initialised to 1 on reset. All decisions use the synchronised value.
- RX FSM states are IDLE, START, DATA, STOP, RECOVER.
  - IDLE -> START on synchronised rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If 0, go to DATA with the baud counter cleared. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles. Eight bits, LSB first, shifted into an 8-bit register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: pulse internal byte_valid for one cycle and return to IDLE.
    - If 0: set frame_err, drop the byte, and go to RECOVER.
  - RECOVER: stay until synchronised rx = 1, then go to IDLE. A break condition therefore never produces bytes.
- Loader (phases KERNEL, IMAGE, DONE). On each byte_valid:
  - KERNEL: on the next clock, wr_data = byte, wr_addr = count, kernel_we = 1 for exactly one cycle, then count increments. When count reaches KERNEL_LEN-1 and that byte is written, kernel_loaded goes to 1 on the same edge as the write strobe, count goes to 0, and the phase moves to IMAGE.
  - IMAGE: same sequence, using image_we. On the byte at count = IMAGE_LEN-1, image_loaded goes to 1 and the phase moves to DONE.
  - DONE: further bytes are received, but no write strobe is asserted and count is unchanged. frame_err tracking still operates.
- kernel_we and image_we are never high in the same cycle.
- Between strobes, wr_addr and wr_data hold their last written values.
- Latency: write strobe asserts 1 clk after the stop-bit sample cycle. This is 2 synchroniser cycles plus about 9.5 bit-times after the start edge.
- Framing errors do not advance count. A dropped byte shifts all later data; host resynchronisation is by reset only.
- Bytes are stored raw. Kernel sign interpretation is the consumer's job.
- Back-to-back frames (a start bit immediately after the stop bit) must be accepted without loss, because IDLE is re-entered at the stop mid-sample.

Test Plan (CLKS_PER_BIT=16, KERNEL_LEN=3, IMAGE_LEN=4, ADDR_W=4):
- Send 0xA5 after reset -> one kernel_we pulse; wr_addr=0, wr_data=0xA5; image_we stays 0; kernel_loaded stays 0.
- Send 0x01,0xFF,0x80 back-to-back, then 0x10,0x20,0x30,0x40 -> kernel_we at addr 0,1,2 with those bytes; kernel_loaded rises with the third strobe; image_we at addr 0..3 with 0x10..0x40; image_loaded rises with the 4th strobe; no overlapping strobes.
- After the load completes, send 0x55 -> no write strobes; both flags stay 1; wr_addr unchanged.
- 6-cycle low glitch on rx while idle -> no strobe; FSM returns to IDLE; the next valid byte 0x3C is written at addr 0.
- Send a frame with stop bit = 0 (data 0x77), hold rx low 40 cycles, release, then send 0x12 -> frame_err = 1 sticky; 0x77 not written; 0x12 written at addr 0.
- Assert reset midway through data bit 4 of the second kernel byte -> all outputs 0 immediately; after release, 0x9A is written to the kernel BRAM at addr 0.
